// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel Wishbone DMA engine: state encoding,
// word stride, byte-select constant and the registered bus request bundle.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_RGAP  = 3'd2,
    ST_WRITE = 3'd3,
    ST_WGAP  = 3'd4,
    ST_DONE  = 3'd5
  } dma_state_t;

  localparam logic [31:0] DMA_STRIDE = 32'd4;
  localparam logic [3:0]  SEL_ALL    = 4'hF;

  // Everything the master drives onto the bus, registered as one unit so an
  // idle bus is simply the all-zero value.
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  localparam wb_req_t REQ_IDLE = '0;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic wb_req_t rd_req(input logic [31:0] adr);
    wb_req_t r;
    r     = REQ_IDLE;
    r.cyc = 1'b1;
    r.stb = 1'b1;
    r.sel = SEL_ALL;
    r.adr = adr;
    return r;
  endfunction

  function automatic wb_req_t wr_req(input logic [31:0] adr, input logic [31:0] dat);
    wb_req_t r;
    r     = rd_req(adr);
    r.we  = 1'b1;
    r.dat = dat;
    return r;
  endfunction

endpackage

// File: rtl/dma_engine_if.sv
// Wishbone master-side bundle between the DMA engine and the CPU/DMA arbiter.
// Handshake: dma_stb_o/dma_cyc_o act as valid and dma_ack_i as ready; a request
// stays asserted and unchanged until the cycle in which dma_ack_i is high, and
// the transfer completes on exactly that cycle (dma_dat_i valid only then).
interface dma_engine_if;
  logic        dma_stb_o;
  logic        dma_cyc_o;
  logic        dma_we_o;
  logic [3:0]  dma_sel_o;
  logic [31:0] dma_adr_o;
  logic [31:0] dma_dat_o;
  logic [31:0] dma_dat_i;
  logic        dma_ack_i;

  modport master (
    output dma_stb_o, dma_cyc_o, dma_we_o, dma_sel_o, dma_adr_o, dma_dat_o,
    input  dma_dat_i, dma_ack_i
  );

  modport slave (
    input  dma_stb_o, dma_cyc_o, dma_we_o, dma_sel_o, dma_adr_o, dma_dat_o,
    output dma_dat_i, dma_ack_i
  );
endinterface

// File: rtl/dma_timeout.sv
// Per-access ack watchdog: counts waiting request cycles and flags the cycle in
// which the wait has lasted LIMIT cycles. Instantiated only with DMA_TIMEOUT_EN.
module dma_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q holds the number of earlier unacknowledged cycles, so the current
  // cycle is the LIMIT-th one when it equals LIMIT-1.
  assign expired = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/dma_engine.sv
// Single-channel Wishbone DMA master copying len 32-bit words from src to dst.
// Optional ack watchdog enabled by defining DMA_TIMEOUT_EN.
module dma_engine
  import dma_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output dma_state_t       dbg_state,
  dma_engine_if.master     bus
);

  dma_state_t       state_q;
  wb_req_t          req_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [LEN_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             abort;

`ifdef DMA_TIMEOUT_EN
  logic req_state;
  assign req_state = (state_q == ST_READ) || (state_q == ST_WRITE);

  dma_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .clr     (!req_state),
    .en      (req_state && !bus.dma_ack_i),
    .expired (abort)
  );
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      req_q   <= REQ_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q <= word_align(src_addr);
            dst_q <= word_align(dst_addr);
            cnt_q <= len;
            err_q <= 1'b0;
            if (len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_READ;
              busy_q  <= 1'b1;
              req_q   <= rd_req(word_align(src_addr));
            end
          end
        end
        ST_READ, ST_WRITE: begin
          // An ack arriving in the expiry cycle still completes the access.
          if (bus.dma_ack_i) begin
            req_q   <= REQ_IDLE;
            state_q <= (state_q == ST_READ) ? ST_RGAP : ST_WGAP;
            if (state_q == ST_READ) data_q <= bus.dma_dat_i;
          end else if (abort) begin
            req_q   <= REQ_IDLE;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        ST_RGAP: begin
          state_q <= ST_WRITE;
          req_q   <= wr_req(dst_q, data_q);
        end
        ST_WGAP: begin
          src_q <= src_q + DMA_STRIDE;
          dst_q <= dst_q + DMA_STRIDE;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_READ;
            req_q   <= rd_req(src_q + DMA_STRIDE);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= REQ_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dma_cyc_o = req_q.cyc;
  assign bus.dma_stb_o = req_q.stb;
  assign bus.dma_we_o  = req_q.we;
  assign bus.dma_sel_o = req_q.sel;
  assign bus.dma_adr_o = req_q.adr;
  assign bus.dma_dat_o = req_q.dat;

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: zero/multi-wait slave, len=0, ignored restart,
// address wrap, reset mid-write and (with DMA_TIMEOUT_EN) the ack watchdog.
module tb_dma_engine;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;
  dma_state_t  dbg_state;

  dma_engine_if bus_if ();

  dma_engine #(.LEN_W(16), .TIMEOUT(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state),
    .bus        (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave model: acks after wait_cfg wait states; read data is a fixed
  // function of the address ({16'hC0DE, adr[15:0]}).
  int wait_cfg = 0;
  bit ack_en = 1'b1;
  int wcnt = 0;

  always_comb begin
    bus_if.dma_ack_i = bus_if.dma_stb_o && ack_en && (wcnt == wait_cfg);
    bus_if.dma_dat_i = bus_if.dma_ack_i ? {16'hC0DE, bus_if.dma_adr_o[15:0]} : 32'h0;
  end

  always @(posedge clk) begin
    if (bus_if.dma_stb_o && !bus_if.dma_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Bus monitor
  logic [31:0] rd_adr_q[$];
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  logic [31:0] exp_q[$];
  int stb_cycles = 0;
  int unstable = 0;
  logic        prev_stb = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_adr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.dma_stb_o) stb_cycles++;
      if (bus_if.dma_stb_o && bus_if.dma_ack_i) begin
        if (bus_if.dma_we_o) begin
          wr_adr_q.push_back(bus_if.dma_adr_o);
          wr_dat_q.push_back(bus_if.dma_dat_o);
        end else begin
          rd_adr_q.push_back(bus_if.dma_adr_o);
        end
      end
      if (prev_stb && !prev_ack && (!bus_if.dma_stb_o || bus_if.dma_adr_o != prev_adr))
        unstable++;
    end
    prev_stb = bus_if.dma_stb_o;
    prev_ack = bus_if.dma_ack_i;
    prev_adr = bus_if.dma_adr_o;
  end

  task automatic clear_logs();
    rd_adr_q.delete();
    wr_adr_q.delete();
    wr_dat_q.delete();
    stb_cycles = 0;
    unstable = 0;
  endtask

  // Pulses start in cycle 0 and observes cycles 1..budget (#1 after each edge).
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int restart_cyc, input int budget,
                          output int done_cyc, output int done_cnt,
                          output logic busy_c1, output logic stb_c1, output logic err_c1);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1; done_cnt = 0;
    busy_c1 = 1'b0; stb_c1 = 1'b0; err_c1 = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (c == 1) begin busy_c1 = busy; stb_c1 = bus_if.dma_stb_o; err_c1 = err; end
      start = (c == restart_cyc);
      if (restart_cyc != 0) begin src_addr = 32'h9000; len = 16'd7; end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic check_copies(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(s + 32'(4 * i));
    checks++;
    if (rd_adr_q.size() !== n || wr_adr_q.size() !== n) begin
      failures++;
      $display("FAIL %s count: reads=%0d writes=%0d expected %0d", tag, rd_adr_q.size(), wr_adr_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rd_adr_q[i] !== exp_q[i] || wr_adr_q[i] !== d + 32'(4 * i) ||
            wr_dat_q[i] !== {16'hC0DE, exp_q[i][15:0]}) begin
          failures++;
          $display("FAIL %s word%0d: rd=%h wr=%h dat=%h expected rd=%h wr=%h dat=%h", tag, i,
                   rd_adr_q[i], wr_adr_q[i], wr_dat_q[i], exp_q[i], d + 32'(4 * i),
                   {16'hC0DE, exp_q[i][15:0]});
        end
      end
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_status: got %b expected 000", {busy, done, err});
    end
    checks++;
    if ({bus_if.dma_stb_o, bus_if.dma_cyc_o, bus_if.dma_we_o, bus_if.dma_sel_o,
         bus_if.dma_adr_o, bus_if.dma_dat_o} !== '0) begin
      failures++;
      $display("FAIL reset_bus: stb=%b adr=%h dat=%h expected all 0", bus_if.dma_stb_o,
               bus_if.dma_adr_o, bus_if.dma_dat_o);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    int dc, dn; logic b1, s1, e1;
    wait_cfg = 0;
    run_xfer(32'h1000, 32'h2000, 16'd3, 0, 40, dc, dn, b1, s1, e1);
    check_int("zw_busy_c1", int'(b1), 1);
    check_int("zw_stb_c1", int'(s1), 1);
    check_int("zw_done_cycle", dc, 13);
    check_int("zw_done_pulses", dn, 1);
    check_int("zw_err", int'(err), 0);
    check_copies("zw", 32'h1000, 32'h2000, 3);
  endtask

  task automatic test_wait_states();
    int dc, dn; logic b1, s1, e1;
    wait_cfg = 2;
    run_xfer(32'h1003, 32'h3000, 16'd1, 0, 30, dc, dn, b1, s1, e1);
    check_int("ws_done_cycle", dc, 9);
    check_int("ws_stb_cycles", stb_cycles, 6);
    check_int("ws_unstable", unstable, 0);
    check_copies("ws", 32'h1000, 32'h3000, 1);
    wait_cfg = 0;
  endtask

  task automatic test_len_zero();
    int dc, dn; logic b1, s1, e1;
    run_xfer(32'h1000, 32'h2000, 16'd0, 0, 10, dc, dn, b1, s1, e1);
    check_int("l0_done_cycle", dc, 1);
    check_int("l0_stb_cycles", stb_cycles, 0);
    check_int("l0_busy_c1", int'(b1), 0);
  endtask

  task automatic test_back_to_back();
    int dc, dn; logic b1, s1, e1;
    run_xfer(32'h1100, 32'h2100, 16'd4, 3, 40, dc, dn, b1, s1, e1);
    check_int("b2b_done_cycle", dc, 17);
    check_int("b2b_done_pulses", dn, 1);
    check_copies("b2b", 32'h1100, 32'h2100, 4);
  endtask

  task automatic test_wrap();
    int dc, dn; logic b1, s1, e1;
    run_xfer(32'hFFFF_FFFC, 32'h4000, 16'd2, 0, 30, dc, dn, b1, s1, e1);
    check_int("wrap_done_cycle", dc, 9);
    check_copies("wrap", 32'hFFFF_FFFC, 32'h4000, 2);
  endtask

  task automatic test_reset_mid_write();
    int dc, dn, seen_done; logic b1, s1, e1; bit hit;
    @(posedge clk); #1;
    src_addr = 32'h5000; dst_addr = 32'h6000; len = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 1; c <= 10 && !hit; c++) begin
      if (bus_if.dma_stb_o && bus_if.dma_we_o) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_int("rmw_reached_write", int'(hit), 1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, bus_if.dma_stb_o, bus_if.dma_cyc_o, bus_if.dma_we_o} !== 6'b0 ||
        {bus_if.dma_sel_o, bus_if.dma_adr_o, bus_if.dma_dat_o} !== '0) begin
      failures++;
      $display("FAIL rmw_outputs: busy=%b stb=%b we=%b adr=%h expected all 0",
               busy, bus_if.dma_stb_o, bus_if.dma_we_o, bus_if.dma_adr_o);
    end
    seen_done = 0;
    repeat (2) begin @(posedge clk); #1; if (done) seen_done++; end
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (done) seen_done++; end
    check_int("rmw_no_done", seen_done, 0);
    check_int("rmw_state_idle", int'(dbg_state), int'(ST_IDLE));
    run_xfer(32'h7000, 32'h8000, 16'd1, 0, 20, dc, dn, b1, s1, e1);
    check_int("rmw_fresh_done_cycle", dc, 5);
    check_copies("rmw_fresh", 32'h7000, 32'h8000, 1);
  endtask

`ifdef DMA_TIMEOUT_EN
  task automatic test_timeout();
    int dc, dn; logic b1, s1, e1;
    ack_en = 1'b0;
    run_xfer(32'h1200, 32'h2200, 16'd3, 0, 40, dc, dn, b1, s1, e1);
    check_int("to_stb_cycles", stb_cycles, 8);
    check_int("to_done_cycle", dc, 9);
    check_int("to_done_pulses", dn, 1);
    check_int("to_err", int'(err), 1);
    check_int("to_writes", wr_adr_q.size(), 0);
    ack_en = 1'b1;
    run_xfer(32'h1300, 32'h2300, 16'd1, 0, 20, dc, dn, b1, s1, e1);
    check_int("to_err_cleared_c1", int'(e1), 0);
    check_int("to_recover_done_cycle", dc, 5);
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_len_zero();
    test_back_to_back();
    test_wrap();
    test_reset_mid_write();
`ifdef DMA_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
